// File: rtl/guess_pkg.sv
// Shared types and helpers for the 1A2B guess/check arbiter.
// The result slices, win threshold, invalid marker and the guess validity
// check live here so the arbiter and any neighbouring blocks agree on them.
package guess_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP,
        S_DONE
    } state_t;

    localparam logic [3:0]  WIN_A       = 4'd4;
    localparam logic [15:0] RES_INVALID = 16'hEEEE;

    // Checker result layout: A count in the top nibble, B count below it
    localparam int RES_A_MSB = 15;
    localparam int RES_A_LSB = 12;
    localparam int RES_B_MSB = 11;
    localparam int RES_B_LSB = 8;

    function automatic logic [3:0] res_a(input logic [15:0] r);
        return r[RES_A_MSB:RES_A_LSB];
    endfunction

    function automatic logic [3:0] res_b(input logic [15:0] r);
        return r[RES_B_MSB:RES_B_LSB];
    endfunction

    // A guess is playable when every digit is BCD and no digit repeats
    function automatic logic guess_valid(input logic [15:0] g);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (g[i*4 +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < 4; j++) begin
                if (g[i*4 +: 4] == g[j*4 +: 4]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/guess_check_arbiter_if.sv
// Player/checker bus of the guess check arbiter.
// slave is the arbiter side; master is the players plus checker side.
interface guess_check_arbiter_if;

    logic [1:0]  req;
    logic [15:0] guess0;
    logic [15:0] guess1;
    logic [15:0] chk_guess;
    logic [15:0] chk_res;
    logic [1:0]  ack;
    logic [15:0] res_out;
    logic [3:0]  tries0;
    logic [3:0]  tries1;
    logic [1:0]  winner;
    logic        game_over;

    modport master (
        output req, guess0, guess1, chk_res,
        input  chk_guess, ack, res_out, tries0, tries1, winner, game_over
    );

    modport slave (
        input  req, guess0, guess1, chk_res,
        output chk_guess, ack, res_out, tries0, tries1, winner, game_over
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. With both inputs requesting, the player
// not served last wins. The last-served pointer starts at player 1 so that
// player 0 is favoured right after reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);

    logic last_q;

    // Grant selection from the request set and the last-served pointer
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember who was served when a completed check is booked
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served;
        end
    end

endmodule

// File: rtl/guess_check_arbiter.sv
// Shares one combinational 1A2B checker between two players.
// Round-robin grants a check, holds the guess for CHECK_LAT cycles, samples
// the result, acks the player for one cycle and tracks tries, lockout, win.
// Optional macro GUESS_VALID_EN: malformed guesses are answered with
// RES_INVALID without using the checker or costing a try.
module guess_check_arbiter
    import guess_pkg::*;
#(
    parameter int MAX_TRIES = 10,
    parameter int CHECK_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_game,
    guess_check_arbiter_if.slave bus
);

    localparam logic [3:0] TRY_MAX  = 4'(MAX_TRIES);
    localparam logic [2:0] LAT_LAST = 3'(CHECK_LAT - 1);

    state_t      state_q;
    logic        gsel_q;
    logic        inv_q;
    logic [2:0]  cnt_q;
    logic [1:0]  mask_q;
    logic [1:0]  ack_q;
    logic [1:0]  winner_q;
    logic [15:0] chk_guess_q;
    logic [15:0] res_q;
    logic [3:0]  tries0_q;
    logic [3:0]  tries1_q;
    logic        game_over_q;

    logic [3:0]  tries0_d;
    logic [3:0]  tries1_d;
    logic        win_d;
    logic        over_d;
    logic        bad_d;

    logic        clr;
    logic        rr_upd;
    logic [1:0]  locked;
    logic [1:0]  elig;
    logic [1:0]  grant;
    logic [15:0] guess_sel;

    function automatic logic [1:0] onehot(input logic s);
        return s ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] t);
        return (t >= TRY_MAX) ? TRY_MAX : t + 4'd1;
    endfunction

    // new_game is a full restart, identical in effect to rst
    assign clr       = rst | new_game;
    assign locked    = {tries1_q == TRY_MAX, tries0_q == TRY_MAX};
    assign elig      = bus.req & ~locked & ~mask_q;
    assign guess_sel = grant[1] ? bus.guess1 : bus.guess0;
    assign rr_upd    = (state_q == S_RESP) && !inv_q;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (clr),
        .req    (elig),
        .update (rr_upd),
        .served (gsel_q),
        .grant  (grant)
    );

    // Try counts and end-of-game decision for the check being sampled now
    always_comb begin
        tries0_d = tries0_q;
        tries1_d = tries1_q;
        if (gsel_q) tries1_d = sat_inc(tries1_q);
        else        tries0_d = sat_inc(tries0_q);
        win_d  = (res_a(bus.chk_res) == WIN_A);
        over_d = win_d || ((tries0_d == TRY_MAX) && (tries1_d == TRY_MAX));
`ifdef GUESS_VALID_EN
        bad_d  = !guess_valid(guess_sel);
`else
        bad_d  = 1'b0;
`endif
    end

    // Check sequencer: grant, hold guess for CHECK_LAT cycles, ack and book-keep
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            gsel_q      <= 1'b0;
            inv_q       <= 1'b0;
            cnt_q       <= '0;
            mask_q      <= '0;
            ack_q       <= '0;
            chk_guess_q <= '0;
            res_q       <= '0;
            tries0_q    <= '0;
            tries1_q    <= '0;
            winner_q    <= '0;
            game_over_q <= 1'b0;
        end else begin
            ack_q  <= 2'b00;
            mask_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (|elig) begin
                        gsel_q <= grant[1];
                        cnt_q  <= '0;
                        if (bad_d) begin
                            // Malformed guess never reaches the checker
                            inv_q   <= 1'b1;
                            res_q   <= RES_INVALID;
                            ack_q   <= grant;
                            state_q <= S_RESP;
                        end else begin
                            inv_q       <= 1'b0;
                            chk_guess_q <= guess_sel;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cnt_q == LAT_LAST) begin
                        res_q       <= bus.chk_res;
                        ack_q       <= onehot(gsel_q);
                        tries0_q    <= tries0_d;
                        tries1_q    <= tries1_d;
                        winner_q    <= win_d ? onehot(gsel_q) : 2'b00;
                        game_over_q <= over_d;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_RESP: begin
                    // Keep the just-served player out of the next arbitration
                    mask_q  <= onehot(gsel_q);
                    state_q <= game_over_q ? S_DONE : S_IDLE;
                end
                default: begin
                    state_q <= S_DONE;
                end
            endcase
        end
    end

    assign bus.chk_guess = chk_guess_q;
    assign bus.ack       = ack_q;
    assign bus.res_out   = res_q;
    assign bus.tries0    = tries0_q;
    assign bus.tries1    = tries1_q;
    assign bus.winner    = winner_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_guess_check_arbiter.sv
// Self-checking bench for guess_check_arbiter: directed scenarios followed by
// randomized two-player games scored against a transaction-level model.
// Expectations adapt to the GUESS_VALID_EN build option.
module tb_guess_check_arbiter;
    import guess_pkg::*;

    localparam int          MAXT   = 3;
    localparam int          LAT    = 2;
    localparam logic [15:0] SECRET = 16'h3917;
`ifdef GUESS_VALID_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic        chk_mode;
    logic [15:0] chk_res_drv;
    int          vectors = 0;
    int          miscompares = 0;

    guess_check_arbiter_if bus ();

    guess_check_arbiter #(.MAX_TRIES(MAXT), .CHECK_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .new_game (new_game),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] score(input logic [15:0] g);
        logic [15:0] s;
        logic [3:0]  a, b;
        s = SECRET; a = 0; b = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (g[4*i +: 4] == s[4*j +: 4]) begin
                    if (i == j) a = a + 4'd1;
                    else        b = b + 4'd1;
                end
        return {a, b, 8'h00};
    endfunction

    function automatic bit digits_ok(input logic [15:0] g);
        bit ok;
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            if (g[4*i +: 4] > 4'd9) ok = 0;
            for (int j = i + 1; j < 4; j++)
                if (g[4*i +: 4] == g[4*j +: 4]) ok = 0;
        end
        return ok;
    endfunction

    function automatic logic [15:0] rand_guess();
        logic [15:0] g;
        case ($urandom_range(0, 5))
            0:       g = SECRET;
            1:       g = 16'($urandom);
            default: g = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        endcase
        return g;
    endfunction

    function automatic logic [1:0] oh(input logic s);
        return s ? 2'b10 : 2'b01;
    endfunction

    // The checker: scores against SECRET in random games, else a driven value
    assign bus.chk_res = chk_mode ? score(bus.chk_guess) : chk_res_drv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit use_ng);
        if (use_ng) new_game = 1'b1;
        else        rst = 1'b1;
        bus.req = 2'b00;
        tick();
        rst = 1'b0;
        new_game = 1'b0;
    endtask

    task automatic serve(input logic [1:0] r, output logic [1:0] ackv, output int lat);
        ackv = 2'b00;
        lat = -1;
        bus.req = r;
        for (int n = 1; n <= 4 * (LAT + 2); n++) begin
            tick();
            if (bus.ack !== 2'b00) begin
                ackv = bus.ack;
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_req(input logic [1:0] ackv);
        tick();
        bus.req = bus.req & ~ackv;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; new_game = 1'b0; bus.req = 2'b00;
        tick();
        tick();
        vectors++;
        if (bus.ack !== 2'b00 || bus.res_out !== 16'h0 || bus.chk_guess !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got ack=%b res=%h chk=%h want 0", bus.ack, bus.res_out, bus.chk_guess);
        end
        vectors++;
        if (bus.tries0 !== 4'd0 || bus.tries1 !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_tries: got %0d/%0d want 0/0", bus.tries0, bus.tries1);
        end
        vectors++;
        if (bus.winner !== 2'b00 || bus.game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_end: got winner=%b over=%b want 00/0", bus.winner, bus.game_over);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset(0);
        chk_mode = 1'b0;
        bus.guess0 = 16'h1234; bus.guess1 = 16'h5678;
        chk_res_drv = 16'h0110;
        bus.req = 2'b01;
        tick();
        vectors++;
        if (bus.chk_guess !== 16'h1234) begin
            miscompares++;
            $display("FAIL single_chk_guess: got %h want 1234", bus.chk_guess);
        end
        bus.req = 2'b00;  // dropped mid-check; the check still completes
        for (int c = 1; c < LAT; c++) tick();
        chk_res_drv = 16'h2010;
        tick();
        vectors++;
        if (bus.ack !== 2'b01 || bus.res_out !== 16'h2010 || bus.tries0 !== 4'd1) begin
            miscompares++;
            $display("FAIL single_ack: got ack=%b res=%h tries0=%0d want 01/2010/1", bus.ack, bus.res_out, bus.tries0);
        end
        chk_res_drv = 16'h0330;
        tick();
        vectors++;
        if (bus.ack !== 2'b00 || bus.res_out !== 16'h2010 || bus.chk_guess !== 16'h1234) begin
            miscompares++;
            $display("FAIL single_hold: got ack=%b res=%h chk=%h want 00/2010/1234", bus.ack, bus.res_out, bus.chk_guess);
        end
    endtask

    task automatic test_rr();
        int          a0, a1, lat;
        logic [1:0]  prev, ackv;
        apply_reset(0);
        chk_mode = 1'b0; chk_res_drv = 16'h0000;
        bus.guess0 = 16'h0123; bus.guess1 = 16'h4567;
        a0 = -1; a1 = -1; prev = 2'b00;
        bus.req = 2'b11;
        for (int c = 1; c <= 3 * (LAT + 2); c++) begin
            tick();
            bus.req = bus.req & ~prev;
            prev = bus.ack;
            if (bus.ack === 2'b01 && a0 < 0) a0 = c;
            if (bus.ack === 2'b10 && a1 < 0) a1 = c;
        end
        vectors++;
        if (a0 != LAT + 1) begin
            miscompares++;
            $display("FAIL rr_first_ack_cycle: got %0d want %0d", a0, LAT + 1);
        end
        vectors++;
        if (a1 != 2 * LAT + 3) begin
            miscompares++;
            $display("FAIL rr_second_ack_cycle: got %0d want %0d", a1, 2 * LAT + 3);
        end
        serve(2'b11, ackv, lat);
        vectors++;
        if (ackv !== 2'b01 || lat != LAT + 1) begin
            miscompares++;
            $display("FAIL rr_alternate: got ack=%b lat=%0d want 01/%0d", ackv, lat, LAT + 1);
        end
        release_req(ackv);
        bus.req = 2'b00;
    endtask

    task automatic test_win();
        logic [1:0] ackv;
        int         lat;
        apply_reset(0);
        chk_mode = 1'b0; chk_res_drv = 16'h4000;
        bus.guess1 = 16'h5678;
        serve(2'b10, ackv, lat);
        vectors++;
        if (ackv !== 2'b10 || bus.winner !== 2'b10 || bus.game_over !== 1'b1 || bus.tries1 !== 4'd1) begin
            miscompares++;
            $display("FAIL win_ack: got ack=%b winner=%b over=%b tries1=%0d want 10/10/1/1", ackv, bus.winner, bus.game_over, bus.tries1);
        end
        release_req(ackv);
        chk_res_drv = 16'h1100;
        serve(2'b11, ackv, lat);
        vectors++;
        if (ackv !== 2'b00) begin
            miscompares++;
            $display("FAIL win_done_ack: got %b want 00", ackv);
        end
        vectors++;
        if (bus.tries0 !== 4'd0 || bus.tries1 !== 4'd1 || bus.winner !== 2'b10 || bus.res_out !== 16'h4000) begin
            miscompares++;
            $display("FAIL win_frozen: got t0=%0d t1=%0d winner=%b res=%h want 0/1/10/4000", bus.tries0, bus.tries1, bus.winner, bus.res_out);
        end
        bus.req = 2'b00;
    endtask

    task automatic test_lockout();
        logic [1:0] ackv;
        int         lat;
        apply_reset(0);
        chk_mode = 1'b0; chk_res_drv = 16'h1200;
        bus.guess0 = 16'h0123; bus.guess1 = 16'h4567;
        for (int i = 0; i < MAXT; i++) begin
            serve(2'b01, ackv, lat);
            vectors++;
            if (ackv !== 2'b01 || bus.tries0 !== 4'(i + 1) || bus.game_over !== 1'b0) begin
                miscompares++;
                $display("FAIL lock_p0_try%0d: got ack=%b tries0=%0d over=%b want 01/%0d/0", i, ackv, bus.tries0, bus.game_over, i + 1);
            end
            release_req(ackv);
        end
        for (int i = 0; i < MAXT; i++) begin
            serve(2'b11, ackv, lat);
            vectors++;
            if (ackv !== 2'b10 || bus.tries1 !== 4'(i + 1)) begin
                miscompares++;
                $display("FAIL lock_p1_try%0d: got ack=%b tries1=%0d want 10/%0d", i, ackv, bus.tries1, i + 1);
            end
            vectors++;
            if (bus.game_over !== (i == MAXT - 1) || bus.winner !== 2'b00) begin
                miscompares++;
                $display("FAIL lock_end%0d: got over=%b winner=%b want %0d/00", i, bus.game_over, bus.winner, i == MAXT - 1);
            end
            release_req(ackv);
        end
        serve(2'b11, ackv, lat);
        vectors++;
        if (ackv !== 2'b00 || bus.tries0 !== 4'(MAXT)) begin
            miscompares++;
            $display("FAIL lock_done: got ack=%b tries0=%0d want 00/%0d", ackv, bus.tries0, MAXT);
        end
        bus.req = 2'b00;
    endtask

    task automatic test_abort();
        logic [1:0] ackv;
        int         lat;
        for (int w = 0; w < 2; w++) begin
            apply_reset(0);
            chk_mode = 1'b0; chk_res_drv = 16'h0200;
            bus.guess0 = 16'h0123;
            serve(2'b01, ackv, lat);
            release_req(ackv);
            bus.req = 2'b01;
            tick();
            if (w == 0) rst = 1'b1;
            else        new_game = 1'b1;
            tick();
            rst = 1'b0; new_game = 1'b0;
            vectors++;
            if ({bus.ack, bus.res_out, bus.chk_guess, bus.tries0, bus.tries1, bus.winner, bus.game_over} !== '0) begin
                miscompares++;
                $display("FAIL abort_clear%0d: got ack=%b res=%h chk=%h t0=%0d want all 0", w, bus.ack, bus.res_out, bus.chk_guess, bus.tries0);
            end
            serve(2'b01, ackv, lat);
            vectors++;
            if (ackv !== 2'b01 || lat != LAT + 1 || bus.tries0 !== 4'd1 || bus.res_out !== 16'h0200) begin
                miscompares++;
                $display("FAIL abort_retry%0d: got ack=%b lat=%0d t0=%0d res=%h want 01/%0d/1/0200", w, ackv, lat, bus.tries0, bus.res_out, LAT + 1);
            end
            release_req(ackv);
            bus.req = 2'b00;
        end
    endtask

    task automatic test_valid();
        logic [1:0]  ackv;
        logic [15:0] gs [2];
        logic [15:0] exp_res, exp_chk;
        int          lat, exp_lat, exp_tries;
        gs[0] = 16'h1123;
        gs[1] = 16'h12A4;
        apply_reset(0);
        chk_mode = 1'b0; chk_res_drv = 16'h1100;
        for (int i = 0; i < 2; i++) begin
            bus.guess0 = gs[i];
`ifdef GUESS_VALID_EN
            exp_lat = 1; exp_res = RES_INVALID; exp_tries = 0; exp_chk = 16'h0000;
`else
            exp_lat = LAT + 1; exp_res = 16'h1100; exp_tries = i + 1; exp_chk = gs[i];
`endif
            serve(2'b01, ackv, lat);
            vectors++;
            if (ackv !== 2'b01 || lat != exp_lat || bus.res_out !== exp_res) begin
                miscompares++;
                $display("FAIL valid_ack%0d: got ack=%b lat=%0d res=%h want 01/%0d/%h", i, ackv, lat, bus.res_out, exp_lat, exp_res);
            end
            vectors++;
            if (bus.tries0 !== 4'(exp_tries) || bus.chk_guess !== exp_chk) begin
                miscompares++;
                $display("FAIL valid_book%0d: got t0=%0d chk=%h want %0d/%h", i, bus.tries0, bus.chk_guess, exp_tries, exp_chk);
            end
            release_req(ackv);
        end
        bus.req = 2'b00;
    endtask

    task automatic test_random();
        logic [1:0]  r, drop, m_ack, m_winner, m_mask, e;
        logic [15:0] g [2];
        logic [15:0] m_res, m_chk, m_gs;
        int          m_tries [2];
        int          ack_cyc, free_cyc;
        bit          over, m_inv;
        logic        m_g, m_last, p;
        chk_mode = 1'b1;
        for (int game = 0; game < 6; game++) begin
            apply_reset(1);
            r = 0; drop = 0; g[0] = 0; g[1] = 0;
            m_res = 0; m_chk = 0; m_gs = 0; m_winner = 0; m_mask = 0;
            m_tries[0] = 0; m_tries[1] = 0;
            ack_cyc = -1; free_cyc = 0; over = 0; m_inv = 0; m_g = 0; m_last = 1;
            for (int k = 0; k < 250; k++) begin
                m_ack = 2'b00;
                if (k == ack_cyc) begin
                    m_ack = oh(m_g);
                    if (m_inv) begin
                        m_res = RES_INVALID;
                    end else begin
                        m_res = score(m_gs);
                        if (m_tries[m_g] < MAXT) m_tries[m_g]++;
                        m_last = m_g;
                        if (m_res[15:12] == 4'd4) begin
                            m_winner = oh(m_g);
                            over = 1;
                        end else if (m_tries[0] == MAXT && m_tries[1] == MAXT) begin
                            over = 1;
                        end
                    end
                end
                vectors++;
                if (bus.ack !== m_ack) begin
                    miscompares++;
                    $display("FAIL rnd_ack: game %0d cycle %0d got %b want %b", game, k, bus.ack, m_ack);
                end
                vectors++;
                if (bus.res_out !== m_res) begin
                    miscompares++;
                    $display("FAIL rnd_res: game %0d cycle %0d got %h want %h", game, k, bus.res_out, m_res);
                end
                vectors++;
                if (bus.chk_guess !== m_chk) begin
                    miscompares++;
                    $display("FAIL rnd_chk_guess: game %0d cycle %0d got %h want %h", game, k, bus.chk_guess, m_chk);
                end
                vectors++;
                if (bus.tries0 !== 4'(m_tries[0]) || bus.tries1 !== 4'(m_tries[1])) begin
                    miscompares++;
                    $display("FAIL rnd_tries: game %0d cycle %0d got %0d/%0d want %0d/%0d", game, k, bus.tries0, bus.tries1, m_tries[0], m_tries[1]);
                end
                vectors++;
                if (bus.winner !== m_winner || bus.game_over !== over) begin
                    miscompares++;
                    $display("FAIL rnd_end: game %0d cycle %0d got %b/%b want %b/%b", game, k, bus.winner, bus.game_over, m_winner, over);
                end
                // Players: hold req until acked, drop it the next cycle, maybe retry later
                for (int i = 0; i < 2; i++) begin
                    if (drop[i]) begin
                        r[i] = 1'b0;
                        drop[i] = 1'b0;
                    end else if (bus.ack[i] === 1'b1) begin
                        drop[i] = 1'b1;
                    end else if (!r[i] && $urandom_range(0, 2) == 0) begin
                        r[i] = 1'b1;
                        g[i] = rand_guess();
                    end
                end
                // Model arbitration for this cycle
                if (!over && k >= free_cyc) begin
                    e = r & ~{m_tries[1] == MAXT, m_tries[0] == MAXT} & ((k == free_cyc) ? ~m_mask : 2'b11);
                    if (e != 2'b00) begin
                        p = (e == 2'b11) ? ~m_last : e[1];
                        m_g = p;
                        m_gs = g[p];
                        m_inv = VEN && !digits_ok(g[p]);
                        ack_cyc = m_inv ? k + 1 : k + 1 + LAT;
                        free_cyc = ack_cyc + 1;
                        m_mask = oh(p);
                        if (!m_inv) m_chk = g[p];
                    end
                end
                bus.req = r; bus.guess0 = g[0]; bus.guess1 = g[1];
                if (over && k > ack_cyc + 4) break;
                tick();
            end
        end
        chk_mode = 1'b0;
        bus.req = 2'b00;
    endtask

    initial begin
        rst = 1'b1; new_game = 1'b0;
        chk_mode = 1'b0; chk_res_drv = 16'h0;
        bus.req = 2'b00; bus.guess0 = 16'h0; bus.guess1 = 16'h0;
        test_reset();
        test_single();
        test_rr();
        test_win();
        test_lockout();
        test_abort();
        test_valid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1);
    end

endmodule
